// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq: two-requester arbiter and stage sequencer for a shared FP add/sub datapath
module fp_addsub_seq #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic        req0_op,
  input  logic        req1_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic [31:0] dp_a,
  output logic [31:0] dp_b,
  output logic        dp_op,
  output logic        step1_en,
  output logic        step2_en,
  output logic        step3_en,
  input  logic [31:0] dp_result,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_result,
  output logic        busy
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ALIGN  = 3'd1;
  localparam logic [2:0] ADDSUB = 3'd2;
  localparam logic [2:0] NORM   = 3'd3;
  localparam logic [2:0] CAPT   = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  logic [2:0]  state_q, state_d;
  logic        last_q, last_d, id_q, id_d, op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic        idle, g0, g1, acc, sop, byp;
  logic [31:0] sa, sb, byp_res;

  always_comb begin
    idle    = state_q == IDLE;
    // last_q==1 means requester 1 won last time, so requester 0 takes the tie
    g1      = idle && !RST && req1_valid && (!req0_valid || (RR_EN && !last_q));
    g0      = idle && !RST && req0_valid && !g1;
    acc     = g0 | g1;
    sa      = g1 ? req1_a : req0_a;
    sb      = g1 ? req1_b : req0_b;
    sop     = g1 ? req1_op : req0_op;
    byp     = sb[30:0] == 31'd0 || sa[30:0] == 31'd0;
    byp_res = sb[30:0] == 31'd0 ? sa : sop ? {~sb[31], sb[30:0]} : sb;
    state_d = idle ? (acc ? (byp ? DONE : ALIGN) : IDLE)
            : state_q == DONE ? (resp_ready ? IDLE : DONE)
            : state_q > DONE ? IDLE : state_q + 3'd1;
    last_d  = acc ? g1 : last_q;
    id_d    = acc ? g1 : id_q;
    a_d     = acc ? sa : a_q;
    b_d     = acc ? sb : b_q;
    op_d    = acc ? sop : op_q;
    res_d   = acc && byp ? byp_res : state_q == CAPT ? dp_result : res_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
    end
  end

  assign req0_ready  = g0;
  assign req1_ready  = g1;
  assign dp_a        = a_q;
  assign dp_b        = b_q;
  assign dp_op       = op_q;
  assign step1_en    = state_q == ALIGN;
  assign step2_en    = state_q == ADDSUB;
  assign step3_en    = state_q == NORM;
  assign resp_valid  = state_q == DONE;
  assign resp_id     = id_q;
  assign resp_result = res_q;
  assign busy        = !idle;
endmodule

// File: tb/tb_fp_addsub_seq.sv
// tb_fp_addsub_seq: directed vector bench for fp_addsub_seq (round-robin and fixed-priority instances)
module tb_fp_addsub_seq;
  typedef struct {
    logic        id;
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0, req0_op = 1'b0, req1_op = 1'b0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        resp_ready = 1'b0;
  logic        rr_r0, rr_r1, rr_op, rr_s1, rr_s2, rr_s3, rr_rv, rr_id, rr_busy;
  logic [31:0] rr_a, rr_b, rr_res, rr_dpr;
  logic        fp_r0, fp_r1, fp_op, fp_s1, fp_s2, fp_s3, fp_rv, fp_id, fp_busy;
  logic [31:0] fp_a, fp_b, fp_res, fp_dpr;
  int          n_cmp = 0, n_bad = 0;
  vec_t        vt[9];

  always #5 clk = ~clk;

  fp_addsub_seq #(.RR_EN(1'b1)) u_rr (
    .CLK(clk), .RST(rst), .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(rr_r0), .req1_ready(rr_r1), .req0_op(req0_op), .req1_op(req1_op),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .dp_a(rr_a), .dp_b(rr_b), .dp_op(rr_op), .step1_en(rr_s1), .step2_en(rr_s2),
    .step3_en(rr_s3), .dp_result(rr_dpr), .resp_valid(rr_rv), .resp_ready(resp_ready),
    .resp_id(rr_id), .resp_result(rr_res), .busy(rr_busy)
  );

  fp_addsub_seq #(.RR_EN(1'b0)) u_fp (
    .CLK(clk), .RST(rst), .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(fp_r0), .req1_ready(fp_r1), .req0_op(req0_op), .req1_op(req1_op),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .dp_a(fp_a), .dp_b(fp_b), .dp_op(fp_op), .step1_en(fp_s1), .step2_en(fp_s2),
    .step3_en(fp_s3), .dp_result(fp_dpr), .resp_valid(fp_rv), .resp_ready(resp_ready),
    .resp_id(fp_id), .resp_result(fp_res), .busy(fp_busy)
  );

  // Datapath stand-in: known single-precision sums, valid only in the cycle after step3_en
  function automatic logic [31:0] dp_model(input logic [31:0] a, input logic [31:0] b, input logic op);
    if (!op && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    if (op && a == 32'h40400000 && b == 32'h3F800000) return 32'h40000000;
    if (!op && a == 32'h40000000 && b == 32'h40000000) return 32'h40800000;
    if (!op && a == 32'h3FC00000 && b == 32'h3F000000) return 32'h40000000;
    return 32'h7FC00000;
  endfunction

  always @(posedge clk) begin
    rr_dpr <= rr_s3 ? dp_model(rr_a, rr_b, rr_op) : 32'hDEADBEEF;
    fp_dpr <= fp_s3 ? dp_model(fp_a, fp_b, fp_op) : 32'hDEADBEEF;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic id, input logic [31:0] a, input logic [31:0] b, input logic op);
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end
  endtask

  task automatic run_op(input vec_t v);
    int lat, s1, s2, s3, ns;
    @(negedge clk);
    drive(v.id, v.a, v.b, v.op);
    #1;
    chk("grant", 32'({rr_r1, rr_r0}), v.id ? 32'd2 : 32'd1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 32'h12345678; req1_a = 32'h87654321; req0_b = '1; req1_b = '1;
    lat = 0; s1 = 0; s2 = 0; s3 = 0; ns = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (rr_s1) s1 = lat;
      if (rr_s2) s2 = lat;
      if (rr_s3) s3 = lat;
      ns += 32'(rr_s1) + 32'(rr_s2) + 32'(rr_s3);
      if (rr_rv) break;
    end
    chk("latency", 32'(lat), 32'(v.lat));
    chk("step_count", 32'(ns), v.lat == 5 ? 32'd3 : 32'd0);
    if (v.lat == 5) chk("step_order", 32'(s1 * 100 + s2 * 10 + s3), 32'd123);
    chk("resp_id", 32'(rr_id), 32'(v.id));
    chk("resp_result", rr_res, v.exp);
    chk("dp_a", rr_a, v.a);
    chk("dp_b", rr_b, v.b);
    chk("dp_op", 32'(rr_op), 32'(v.op));
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    chk("idle_after_resp", 32'({rr_busy, rr_rv}), 32'd0);
  endtask

  initial begin
    int ids_rr[$], ids_fp[$], bad, w;
    logic [31:0] held;
    vt[0] = '{1'b0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 5};
    vt[1] = '{1'b1, 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 5};
    vt[2] = '{1'b1, 32'h41200000, 32'h80000000, 1'b1, 32'h41200000, 1};
    vt[3] = '{1'b0, 32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 1};
    vt[4] = '{1'b0, 32'h80000000, 32'hC0000000, 1'b0, 32'hC0000000, 1};
    vt[5] = '{1'b1, 32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 5};
    vt[6] = '{1'b0, 32'h3FC00000, 32'h3F000000, 1'b0, 32'h40000000, 5};
    vt[7] = '{1'b1, 32'h40490FDB, 32'h00000000, 1'b0, 32'h40490FDB, 1};
    vt[8] = '{1'b0, 32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 1};

    // Reset with both requesters pending: nothing may be granted
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'({rr_r0, rr_r1, fp_r0, fp_r1}), 32'd0);
    chk("rst_status", 32'({rr_busy, rr_rv, rr_s1, rr_s2, rr_s3, rr_id, rr_op}), 32'd0);
    chk("rst_data", rr_a | rr_b | rr_res, 32'd0);
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;

    foreach (vt[i]) run_op(vt[i]);

    // Contention from reset: round-robin alternates, fixed priority always picks 0
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 32'h3F800000, 32'h40000000, 1'b0);
    drive(1'b1, 32'h40000000, 32'h40000000, 1'b0);
    resp_ready = 1'b1;
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (rr_rv && (rr_r0 || rr_r1)) bad++;
      if (rr_rv && ids_rr.size() < 4) ids_rr.push_back(int'(rr_id));
      if (fp_rv && ids_fp.size() < 4) ids_fp.push_back(int'(fp_id));
    end
    chk("no_grant_in_done", 32'(bad), 32'd0);
    chk("rr_count", 32'(ids_rr.size()), 32'd4);
    chk("fp_count", 32'(ids_fp.size()), 32'd4);
    for (int k = 0; k < 4 && k < ids_rr.size(); k++) chk("rr_grant_seq", 32'(ids_rr[k]), 32'(k % 2));
    for (int k = 0; k < 4 && k < ids_fp.size(); k++) chk("fp_grant_seq", 32'(ids_fp[k]), 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    w = 0;
    while ((rr_busy || fp_busy) && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("contention_drain", 32'({rr_busy, fp_busy}), 32'd0);
    resp_ready = 1'b0;

    // Backpressure: response held for 10 cycles with both requesters waiting
    @(negedge clk);
    drive(1'b0, 32'h3F800000, 32'h40000000, 1'b0);
    @(posedge clk);
    #1 req0_valid = 1'b0;
    w = 0;
    while (!rr_rv && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("bp_reach_done", 32'(rr_rv), 32'd1);
    held = rr_res;
    chk("bp_result", held, 32'h40400000);
    req0_valid = 1'b1; req1_valid = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!rr_rv || !rr_busy || rr_r0 || rr_r1 || rr_res !== held || rr_id !== 1'b0) bad++;
    end
    chk("bp_stable", 32'(bad), 32'd0);
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    chk("bp_release", 32'({rr_busy, rr_rv}), 32'd0);

    // Reset while in ADDSUB drops the operation
    @(negedge clk);
    drive(1'b0, 32'h40400000, 32'h3F800000, 1'b1);
    @(posedge clk);
    #1 req0_valid = 1'b0;
    w = 0;
    while (!rr_s2 && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("mid_reach_addsub", 32'(rr_s2), 32'd1);
    rst = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    chk("mid_rst_state", 32'({rr_busy, rr_rv, rr_s1, rr_s2, rr_s3, rr_r0, rr_r1}), 32'd0);
    chk("mid_rst_data", rr_a | rr_b | rr_res, 32'd0);
    rst = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    chk("mid_no_resp", 32'({rr_busy, rr_rv}), 32'd0);
    run_op(vt[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/fp_addsub_seq.md
FP_ADDSUB_SEQ -- requirements
Module: fp_addsub_seq

Purpose: two-requester arbiter and stage sequencer for the shared single-precision add/sub datapath (align -> signed add/sub -> normalize/round).

Interface
REQ-001 Parameter RR_EN, default 1: 1 = round-robin arbitration; 0 = fixed priority, requester 0 wins.
REQ-002 One clock, CLK; reset RST is synchronous and active-high.
REQ-003 CLK  in  1  clock; all state updates on its rising edge.
REQ-004 RST  in  1  synchronous active-high reset.
REQ-005 req0_valid / req1_valid  in  1  requester N has an operation pending.
REQ-006 req0_ready / req1_ready  out  1  requester N's operation is accepted this cycle.
REQ-007 req0_op / req1_op  in  1  0 = add, 1 = subtract (a - b).
REQ-008 req0_a, req0_b, req1_a, req1_b  in  32  IEEE-754 single operands.
REQ-009 dp_a, dp_b  out  32  latched operands driven to the datapath; dp_op  out  1  latched op.
REQ-010 step1_en, step2_en, step3_en  out  1  one-hot stage enables: align, add/sub, normalize/round.
REQ-011 dp_result  in  32  datapath output, valid in the cycle after step3_en.
REQ-012 resp_valid  out  1; resp_ready  in  1; resp_id  out  1 (requester number); resp_result  out  32.
REQ-013 busy  out  1  high in every state except IDLE.

Function
REQ-014 FSM states: IDLE, ALIGN, ADDSUB, NORM, CAPT, DONE.
REQ-015 IDLE: when any reqN_valid is high, assert exactly one reqN_ready (grant) combinationally and latch a, b, op and id on that edge.
REQ-016 Grant with RR_EN=1: if both valid, grant the requester not granted last; the last-grant pointer resets to 1, so requester 0 wins first.
REQ-017 Grant with RR_EN=0: requester 0 always wins a tie.
REQ-018 reqN_ready is low in every state other than IDLE.
REQ-019 Normal path: IDLE -> ALIGN (step1_en=1) -> ADDSUB (step2_en=1) -> NORM (step3_en=1) -> CAPT (latch dp_result into resp_result) -> DONE.
REQ-020 Each of ALIGN, ADDSUB, NORM and CAPT lasts exactly one cycle.
REQ-021 Normal-path latency: resp_valid rises 5 cycles after the accept edge.
REQ-022 Zero-operand bypass: if the latched b[30:0]==0, go IDLE -> DONE with resp_result = a.
REQ-023 Zero-operand bypass: else if a[30:0]==0, go IDLE -> DONE with resp_result = b for add, or {~b[31], b[30:0]} for subtract.
REQ-024 Bypass latency is 1 cycle, and no stepN_en is asserted.
REQ-025 DONE: hold resp_valid=1 with resp_id and resp_result stable until resp_ready=1; that edge returns to IDLE.
REQ-026 No new grant occurs in the DONE/IDLE transition cycle; the next grant is earliest one cycle later.
REQ-027 step1_en, step2_en and step3_en are mutually exclusive and each is high for exactly one cycle per non-bypass operation.
REQ-028 dp_a, dp_b and dp_op stay constant from the accept edge until the DONE exit edge.
REQ-029 A requester dropping reqN_valid after acceptance has no effect.
REQ-030 The last-grant pointer updates only on an accept edge.

Reset
REQ-031 RST=1 at a clock edge forces IDLE, including mid-operation.
REQ-032 RST=1 at a clock edge drives resp_valid=0, busy=0, stepN_en=0, req0_ready=req1_ready=0 and last-grant=1.
REQ-033 RST=1 at a clock edge clears resp_result, resp_id, dp_a, dp_b and dp_op to 0.
REQ-034 An in-flight operation is dropped on reset without a response.
REQ-035 No grant is issued in any cycle where RST=1.

Verification
REQ-036 Single add: req0 a=0x3F800000, b=0x40000000, op=0, with a datapath model -> step1/2/3 pulse on cycles 1/2/3; resp_valid at cycle 5 with resp_id=0, resp_result=0x40400000.
REQ-037 Contention with RR_EN=1, both valid continuously, resp_ready=1 -> grants alternate 0,1,0,1; with RR_EN=0 -> every grant goes to requester 0.
REQ-038 Bypass: req1 a=0x41200000, b=0x80000000, op=1 -> resp_valid after 1 cycle, resp_result=0x41200000, resp_id=1, no stepN_en.
REQ-039 Bypass: a=0x00000000, b=0x3F800000, op=1 -> resp_result=0xBF800000.
REQ-040 Backpressure: resp_ready held 0 for 10 cycles in DONE -> resp_valid and resp_result stable, reqN_ready low, busy=1; one cycle after resp_ready=1 -> idle.
REQ-041 Reset in ADDSUB: RST=1 for one cycle -> next cycle IDLE, busy=0, no response; a new request is accepted normally.
